// File: rtl/urv_mul_seq_pkg.sv
// Shared definitions for the RV32M multiply sequencer.
// Contents: datapath widths, funct3 codes, FSM state encoding,
// the latched operation context and the operand decode helper.
package urv_mul_seq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ACC_W     = 64;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned MUL_IN_W  = 18;
    localparam int unsigned MUL_OUT_W = 36;

    localparam logic [2:0] URV_FUN_MUL    = 3'b000;
    localparam logic [2:0] URV_FUN_MULH   = 3'b001;
    localparam logic [2:0] URV_FUN_MULHSU = 3'b010;
    localparam logic [2:0] URV_FUN_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        URV_MSEQ_IDLE  = 3'd0,
        URV_MSEQ_ISSUE = 3'd1,
        URV_MSEQ_DRAIN = 3'd2,
        URV_MSEQ_FIX   = 3'd3,
        URV_MSEQ_DONE  = 3'd4
    } mseq_state_t;

    // Operation context captured when a request is accepted
    typedef struct packed {
        logic [XLEN-1:0] ma;      // |a|
        logic [XLEN-1:0] mb;      // |b|
        logic            neg;     // final product must be negated
        logic            hi_sel;  // return upper word
    } mul_op_t;

    // Reduce signed operands to magnitudes plus a result-sign flag.
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    function automatic mul_op_t decode_op(input logic [2:0]      fun,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic    sa;
        logic    sb;
        mul_op_t op;
        sa        = a[XLEN-1] & ((fun == URV_FUN_MULH) | (fun == URV_FUN_MULHSU));
        sb        = b[XLEN-1] & (fun == URV_FUN_MULH);
        op.ma     = sa ? -a : a;
        op.mb     = sb ? -b : b;
        op.neg    = sa ^ sb;
        op.hi_sel = (fun != URV_FUN_MUL);
        return op;
    endfunction

endpackage

// File: rtl/urv_mul_seq_if.sv
// Request/response bundle between the execute stage and the multiply sequencer.
// master: start_i, d_fun_i, d_rs1_i, d_rs2_i out; busy_o, done_o, w_rd_o in.
// slave : the reverse.
interface urv_mul_seq_if;
    import urv_mul_seq_pkg::*;

    logic            start_i;
    logic [2:0]      d_fun_i;
    logic [XLEN-1:0] d_rs1_i;
    logic [XLEN-1:0] d_rs2_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] w_rd_o;

    modport master (
        output start_i, d_fun_i, d_rs1_i, d_rs2_i,
        input  busy_o, done_o, w_rd_o
    );

    modport slave (
        input  start_i, d_fun_i, d_rs1_i, d_rs2_i,
        output busy_o, done_o, w_rd_o
    );

endinterface

// File: rtl/urv_mul_seq_mult18x18.sv
// Pipelined 18x18 unsigned multiplier with one registered stage.
// Ports: clk_i, rst_i (sync, active-high), stall_i (holds the output register),
//        a_i/b_i 18-bit operands, q_o 36-bit product one cycle later.
module urv_mul_seq_mult18x18
    import urv_mul_seq_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic [MUL_IN_W-1:0]  a_i,
    input  logic [MUL_IN_W-1:0]  b_i,
    output logic [MUL_OUT_W-1:0] q_o
);

    logic [MUL_OUT_W-1:0] r_q;

    // Product register, clock-enabled by the pipeline freeze
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (!stall_i) begin
            r_q <= MUL_OUT_W'(a_i) * MUL_OUT_W'(b_i);
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/urv_mul_seq.sv
// Iterative 32x32 multiply sequencer for MUL/MULH/MULHSU/MULHU.
// Feeds four 16x16 magnitude partials through one 18x18 multiplier,
// accumulates them into a 64-bit sum and applies the sign at the end.
// Ports: clk_i, rst_n_i (sync, active-low), x_stall_i (freeze),
//        abort_i (flush), bus (slave side of urv_mul_seq_if).
module urv_mul_seq
    import urv_mul_seq_pkg::*;
#(
    parameter bit g_sign_fix_stage = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         x_stall_i,
    input  logic         abort_i,
    urv_mul_seq_if.slave bus
);

    mseq_state_t          r_state, w_state_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [1:0]           r_idx;
    mul_op_t              r_op;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_partial;
    logic [ACC_W-1:0]     w_acc_sum;
    logic [ACC_W-1:0]     w_res;
    logic                 r_tag_vld;
    logic [1:0]           r_tag_sh;   // partial shift in units of 16 bits
    logic [XLEN-1:0]      r_rd;
    logic                 w_accept;
    logic                 w_fix_en;
    logic [HALF_W-1:0]    w_a_half;
    logic [HALF_W-1:0]    w_b_half;
    logic [MUL_OUT_W-1:0] w_mul_q;
    logic                 w_unused_q;

    assign w_accept = bus.start_i && !x_stall_i && !abort_i &&
                      ((r_state == URV_MSEQ_IDLE) || (r_state == URV_MSEQ_DONE));

    // Sign fix happens in FIX, or in DRAIN when the extra stage is dropped
    assign w_fix_en = !x_stall_i && !abort_i &&
                      ((r_state == URV_MSEQ_FIX) ||
                       (!g_sign_fix_stage && (r_state == URV_MSEQ_DRAIN)));

    // Slot order: lo*lo, lo*hi, hi*lo, hi*hi
    assign w_a_half = r_idx[1] ? r_op.ma[XLEN-1:HALF_W] : r_op.ma[HALF_W-1:0];
    assign w_b_half = r_idx[0] ? r_op.mb[XLEN-1:HALF_W] : r_op.mb[HALF_W-1:0];

    urv_mul_seq_mult18x18 u_mult (
        .clk_i   (clk_i),
        .rst_i   (~rst_n_i),
        .stall_i (x_stall_i),
        .a_i     (MUL_IN_W'(w_a_half)),
        .b_i     (MUL_IN_W'(w_b_half)),
        .q_o     (w_mul_q)
    );

    // 16x16 partials never exceed 32 bits
    assign w_unused_q = ^w_mul_q[MUL_OUT_W-1:XLEN];

    // Align the emerging partial by its delayed shift tag
    always_comb begin
        w_partial = '0;
        if (r_tag_vld) begin
            case (r_tag_sh)
                2'd0:    w_partial = ACC_W'(w_mul_q[XLEN-1:0]);
                2'd1:    w_partial = {16'b0, w_mul_q[XLEN-1:0], 16'b0};
                default: w_partial = {w_mul_q[XLEN-1:0], 32'b0};
            endcase
        end
    end

    assign w_acc_sum = r_acc + w_partial;
    assign w_res     = r_op.neg ? -w_acc_sum : w_acc_sum;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= URV_MSEQ_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state and registered busy/done
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = URV_MSEQ_IDLE;
        end else if (!x_stall_i) begin
            case (r_state)
                URV_MSEQ_IDLE,
                URV_MSEQ_DONE:  w_state_nxt = bus.start_i ? URV_MSEQ_ISSUE : URV_MSEQ_IDLE;
                URV_MSEQ_ISSUE: if (r_idx == 2'd3) w_state_nxt = URV_MSEQ_DRAIN;
                URV_MSEQ_DRAIN: w_state_nxt = g_sign_fix_stage ? URV_MSEQ_FIX : URV_MSEQ_DONE;
                URV_MSEQ_FIX:   w_state_nxt = URV_MSEQ_DONE;
                default:        w_state_nxt = URV_MSEQ_IDLE;
            endcase
        end
        w_busy_nxt = (w_state_nxt == URV_MSEQ_ISSUE) || (w_state_nxt == URV_MSEQ_DRAIN) ||
                     (w_state_nxt == URV_MSEQ_FIX);
        w_done_nxt = (w_state_nxt == URV_MSEQ_DONE);
    end

    // Operand capture, slot counter, accumulator and result register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_op      <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            r_tag_vld <= 1'b0;
            r_tag_sh  <= '0;
            r_rd      <= '0;
        end else if (abort_i) begin
            r_tag_vld <= 1'b0;
        end else if (!x_stall_i) begin
            r_tag_vld <= (r_state == URV_MSEQ_ISSUE);
            r_tag_sh  <= {1'b0, r_idx[1]} + {1'b0, r_idx[0]};
            if (w_accept) begin
                r_op  <= decode_op(bus.d_fun_i, bus.d_rs1_i, bus.d_rs2_i);
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                if (r_busy) r_acc <= w_acc_sum;
                if (r_state == URV_MSEQ_ISSUE) r_idx <= r_idx + 2'd1;
            end
            if (w_fix_en) begin
                r_rd <= r_op.hi_sel ? w_res[ACC_W-1:XLEN] : w_res[XLEN-1:0];
            end
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.w_rd_o = r_rd;

endmodule

// File: tb/tb_urv_mul_seq.sv
// Self-checking bench for urv_mul_seq: directed corner products, stall,
// abort, back-to-back issue, mid-operation reset and randomized operations
// compared against a plain-arithmetic 64-bit reference.
module tb_urv_mul_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic x_stall;
    logic abort;
    int   n_checks;
    int   n_errors;
    logic [31:0] last_exp;

    urv_mul_seq_if bus ();

    urv_mul_seq #(.g_sign_fix_stage(1'b1)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .x_stall_i (x_stall),
        .abort_i   (abort),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Reference: sign/zero-extend to 64 bits, multiply, pick the word
    function automatic logic [31:0] ref_mul(input logic [2:0] fun,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (fun == 3'd1 || fun == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (fun == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (fun == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'hFFFF_FFFF;
            5:       v = 32'h0000_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present a request across one rising edge; caller sits at a negedge
    task automatic issue(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.d_fun_i = fun;
        bus.d_rs1_i = a;
        bus.d_rs2_i = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Count negedges after the accept edge until done_o; -1 on timeout
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (bus.done_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        n_checks++;
        if (bus.done_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_done: got %b expected 0", bus.done_o);
        end
        n_checks++;
        if (bus.w_rd_o !== 32'h0) begin
            n_errors++; $display("FAIL reset_rd: got %h expected 00000000", bus.w_rd_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  fun_t [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd2};
        logic [31:0] a_t   [6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b_t   [6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                   32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e_t   [6] = '{32'h00000001, 32'h3FFFFFFF, 32'h40000000,
                                   32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(fun_t[i], a_t[i], b_t[i]);
            wait_done(20, lat);
            n_checks++;
            if (lat !== 7) begin
                n_errors++; $display("FAIL directed_lat[%0d]: got %0d expected 7", i, lat);
            end
            n_checks++;
            if (bus.w_rd_o !== e_t[i]) begin
                n_errors++;
                $display("FAIL directed_rd[%0d]: got %h expected %h", i, bus.w_rd_o, e_t[i]);
            end
            last_exp = e_t[i];
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int lat;
        issue(3'd3, 32'h12345678, 32'h9ABCDEF0);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) x_stall = 1'b1;
            if (n == 4) x_stall = 1'b0;
            if (bus.done_o) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat !== 10) begin
            n_errors++; $display("FAIL stall_lat: got %0d expected 10", lat);
        end
        n_checks++;
        if (bus.w_rd_o !== 32'h0B00EA4E) begin
            n_errors++; $display("FAIL stall_rd: got %h expected 0b00ea4e", bus.w_rd_o);
        end
        last_exp = 32'h0B00EA4E;
        // Freeze in DONE: done holds and a pending start is ignored
        x_stall = 1'b1;
        bus.start_i = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.done_o, bus.busy_o} !== 2'b10) begin
                n_errors++;
                $display("FAIL stall_done_hold[%0d]: got done=%b busy=%b expected done=1 busy=0",
                         n, bus.done_o, bus.busy_o);
            end
        end
        x_stall = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL stall_release: got done=%b busy=%b expected 0 0", bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        issue(3'd0, 32'h12345678, 32'h9ABCDEF0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({bus.busy_o, bus.done_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", bus.busy_o, bus.done_o);
        end
        n_checks++;
        if (bus.w_rd_o !== last_exp) begin
            n_errors++; $display("FAIL abort_rd_kept: got %h expected %h", bus.w_rd_o, last_exp);
        end
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen);
        end
        issue(3'd0, 32'd3, 32'd5);
        wait_done(20, lat);
        n_checks++;
        if (lat !== 7) begin
            n_errors++; $display("FAIL abort_next_lat: got %0d expected 7", lat);
        end
        n_checks++;
        if (bus.w_rd_o !== 32'h0000000F) begin
            n_errors++; $display("FAIL abort_next_rd: got %h expected 0000000f", bus.w_rd_o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        int lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        issue(3'd0, a1, b1);
        wait_done(20, lat);
        n_checks++;
        if (lat !== 7 || bus.w_rd_o !== ref_mul(3'd0, a1, b1)) begin
            n_errors++;
            $display("FAIL b2b_first: got lat=%0d rd=%h expected lat=7 rd=%h",
                     lat, bus.w_rd_o, ref_mul(3'd0, a1, b1));
        end
        // Issue from within the DONE cycle
        issue(3'd1, a2, b2);
        @(negedge clk);
        n_checks++;
        if ({bus.busy_o, bus.done_o} !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", bus.busy_o, bus.done_o);
        end
        wait_done(20, lat);
        n_checks++;
        if (lat !== 6) begin
            n_errors++; $display("FAIL b2b_second_lat: got %0d expected 7", lat + 1);
        end
        n_checks++;
        if (bus.w_rd_o !== ref_mul(3'd1, a2, b2)) begin
            n_errors++;
            $display("FAIL b2b_second_rd: got %h expected %h", bus.w_rd_o, ref_mul(3'd1, a2, b2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({bus.busy_o, bus.done_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL rstmid_idle: got busy=%b done=%b expected 0 0", bus.busy_o, bus.done_o);
        end
        n_checks++;
        if (bus.w_rd_o !== 32'h0) begin
            n_errors++; $display("FAIL rstmid_rd: got %h expected 00000000", bus.w_rd_o);
        end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done_o) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [2:0]  fun;
        logic [31:0] a, b, exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            fun = 3'($urandom_range(0, 3));
            a   = rnd_operand();
            b   = rnd_operand();
            exp = ref_mul(fun, a, b);
            issue(fun, a, b);
            wait_done(20, lat);
            n_checks++;
            if (lat !== 7) begin
                n_errors++; $display("FAIL rand_lat[%0d]: got %0d expected 7", i, lat);
            end
            n_checks++;
            if (bus.w_rd_o !== exp) begin
                n_errors++;
                $display("FAIL rand_rd[%0d]: fun=%0d a=%h b=%h got %h expected %h",
                         i, fun, a, b, bus.w_rd_o, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        last_exp    = '0;
        rst_n       = 1'b0;
        x_stall     = 1'b0;
        abort       = 1'b0;
        bus.start_i = 1'b0;
        bus.d_fun_i = '0;
        bus.d_rs1_i = '0;
        bus.d_rs2_i = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
